// File: rtl/cr_fifo_arb_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : cr_fifo_arb_pkg
//  Purpose  : Shared types and helpers for the FIFO write arbiter.
//             - arbiter state encoding (IDLE / LOCKED)
//             - default FIFO data width
//             - rr_pick(): rotating-priority scan returning {found, idx}
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package cr_fifo_arb_pkg;

    localparam int C_DATA_W  = 106;  // default FIFO word width
    localparam int C_MAX_REQ = 8;    // largest supported producer count
    localparam int C_IDX_W   = 3;    // index width covering C_MAX_REQ

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic               found;
        logic [C_IDX_W-1:0] idx;
    } rr_pick_t;

    // First set bit of 'valid' at or after 'ptr', wrapping at n_req-1 -> 0.
    // Bits at or above n_req are never considered.
    function automatic rr_pick_t rr_pick(
        input logic [C_MAX_REQ-1:0] valid,
        input logic [C_IDX_W-1:0]   ptr,
        input logic [C_IDX_W:0]     n_req
    );
        rr_pick_t         res;
        logic [C_IDX_W:0] pos;
        res = '0;
        for (int k = 0; k < C_MAX_REQ; k++) begin
            // ptr < n_req and k < n_req, so one subtraction completes the wrap
            pos = {1'b0, ptr} + (C_IDX_W+1)'(k);
            if (pos >= n_req) begin
                pos = pos - n_req;
            end
            if (!res.found && ((C_IDX_W+1)'(k) < n_req) && valid[pos[C_IDX_W-1:0]]) begin
                res.found = 1'b1;
                res.idx   = pos[C_IDX_W-1:0];
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cr_fifo_wr_arb_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : cr_fifo_wr_arb_if
//  Purpose  : Producer-side request bus and FIFO write port of the arbiter.
//  Signals  : req_valid/req_last/req_data  producer beats (N_REQ lanes)
//             req_ready                    per-producer accept
//             fifo_wen/fifo_wdata          FIFO write port
//             fifo_full/fifo_afull         FIFO status flags
//  Modports : master - producers + FIFO model side
//             slave  - arbiter side
//  Revision : 1.0 - initial release
// ============================================================================
interface cr_fifo_wr_arb_if
    import cr_fifo_arb_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int DATA_W = C_DATA_W
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_last;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_ready;
    logic                    fifo_wen;
    logic [DATA_W-1:0]       fifo_wdata;
    logic                    fifo_full;
    logic                    fifo_afull;

    modport master (
        output req_valid, req_last, req_data, fifo_full, fifo_afull,
        input  req_ready, fifo_wen, fifo_wdata
    );

    modport slave (
        input  req_valid, req_last, req_data, fifo_full, fifo_afull,
        output req_ready, fifo_wen, fifo_wdata
    );
endinterface
`default_nettype wire

// File: rtl/cr_rr_pick.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : cr_rr_pick
//  Purpose  : Combinational rotating-priority selector.
//  Ports    : valid [N_REQ]  request vector
//             ptr   [ID_W]   highest-priority position
//             idx   [ID_W]   chosen requester
//             found          at least one request present
//  Revision : 1.0 - initial release
// ============================================================================
module cr_rr_pick
    import cr_fifo_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
)(
    input  wire [N_REQ-1:0] valid,
    input  wire [ID_W-1:0]  ptr,
    output logic [ID_W-1:0] idx,
    output logic            found
);

    logic [C_MAX_REQ-1:0] w_valid_ext;
    logic [C_IDX_W-1:0]   w_ptr_ext;
    rr_pick_t             w_pick;
    logic                 w_unused_idx;

    always_comb begin
        w_valid_ext              = '0;
        w_valid_ext[N_REQ-1:0]   = valid;
        w_ptr_ext                = '0;
        w_ptr_ext[ID_W-1:0]      = ptr;
        w_pick = rr_pick(w_valid_ext, w_ptr_ext, (C_IDX_W+1)'(N_REQ));
    end

    assign idx          = w_pick.idx[ID_W-1:0];
    assign found        = w_pick.found;
    assign w_unused_idx = ^w_pick.idx;

endmodule
`default_nettype wire

// File: rtl/cr_fifo_wr_arb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : cr_fifo_wr_arb
//  Purpose  : Round-robin, packet-locked arbiter sharing one FIFO write port
//             among N_REQ producers. New grants are withheld while the FIFO
//             is almost full; a packet in flight runs until the FIFO is full.
//  Ports    : clk, rst_n    clock, asynchronous active-low reset
//             bus (slave)   producer beats + FIFO write port/flags
//             busy          packet in progress
//             owner         current or last packet owner
//             proto_err     sticky: owner withdrew a pending beat
//             err_clr       clears proto_err (set wins)
//  Revision : 1.0 - initial release
// ============================================================================
module cr_fifo_wr_arb
    import cr_fifo_arb_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int DATA_W = C_DATA_W,
    parameter int ID_W   = $clog2(N_REQ)
)(
    input  wire              clk,
    input  wire              rst_n,
    cr_fifo_wr_arb_if.slave  bus,
    output logic             busy,
    output logic [ID_W-1:0]  owner,
    output logic             proto_err,
    input  wire              err_clr
);

    arb_state_e      r_state,   w_state_nxt;
    logic [ID_W-1:0] r_rr_ptr,  w_rr_ptr_nxt;
    logic [ID_W-1:0] r_owner,   w_owner_nxt;
    logic            r_proto_err, w_proto_err_nxt;
    logic            r_owner_valid_q, w_owner_valid_nxt;

    logic [ID_W-1:0]  w_pick_idx;
    logic             w_pick_found;
    logic [ID_W-1:0]  w_sel;
    logic             w_sel_ok;
    logic             w_sel_valid;
    logic             w_sel_last;
    logic             w_accept;
    logic             w_err_set;
    logic [N_REQ-1:0] w_ready;

    function automatic logic [ID_W-1:0] inc_wrap(input logic [ID_W-1:0] x);
        return (x == ID_W'(N_REQ-1)) ? '0 : x + ID_W'(1);
    endfunction

    cr_rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_pick (
        .valid (bus.req_valid),
        .ptr   (r_rr_ptr),
        .idx   (w_pick_idx),
        .found (w_pick_found)
    );

    // ------------------------------------------------------------------
    // Select and handshake. In LOCKED the owner is always selected and
    // afull is ignored so the open packet can drain until full.
    // ------------------------------------------------------------------
    always_comb begin
        w_sel       = (r_state == ST_LOCKED) ? r_owner : w_pick_idx;
        w_sel_ok    = (r_state == ST_LOCKED) ? 1'b1 : (w_pick_found & ~bus.fifo_afull);
        w_sel_valid = bus.req_valid[w_sel];
        w_sel_last  = bus.req_last[w_sel];
        w_accept    = w_sel_valid & w_sel_ok & ~bus.fifo_full;
        w_ready     = '0;
        if (w_sel_ok && !bus.fifo_full) begin
            w_ready[w_sel] = 1'b1;
        end
    end

    assign bus.req_ready  = w_ready;
    assign bus.fifo_wen   = w_accept;
    assign bus.fifo_wdata = bus.req_data[w_sel*DATA_W +: DATA_W];

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_rr_ptr_nxt = r_rr_ptr;
        w_owner_nxt  = r_owner;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_sel_last) begin
                        w_rr_ptr_nxt = inc_wrap(w_sel);
                    end else begin
                        w_state_nxt = ST_LOCKED;
                        w_owner_nxt = w_sel;
                    end
                end
            end
            ST_LOCKED: begin
                if (w_accept && w_sel_last) begin
                    w_state_nxt  = ST_IDLE;
                    w_rr_ptr_nxt = inc_wrap(r_owner);
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        // Remember a pending (valid, not accepted) owner beat; if valid is
        // gone next cycle the producer withdrew it.
        w_owner_valid_nxt = (r_state == ST_LOCKED) & w_sel_valid & ~w_accept;
        w_err_set         = (r_state == ST_LOCKED) & r_owner_valid_q & ~w_sel_valid;
        w_proto_err_nxt   = w_err_set | (r_proto_err & ~err_clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= ST_IDLE;
            r_rr_ptr        <= '0;
            r_owner         <= '0;
            r_proto_err     <= 1'b0;
            r_owner_valid_q <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_rr_ptr        <= w_rr_ptr_nxt;
            r_owner         <= w_owner_nxt;
            r_proto_err     <= w_proto_err_nxt;
            r_owner_valid_q <= w_owner_valid_nxt;
        end
    end

    assign busy      = (r_state == ST_LOCKED);
    assign owner     = r_owner;
    assign proto_err = r_proto_err;

endmodule
`default_nettype wire

// File: tb/tb_cr_fifo_wr_arb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_cr_fifo_wr_arb
//  Purpose  : Directed self-checking bench for cr_fifo_wr_arb (N_REQ=4).
//             Inputs change just after the falling edge, combinational
//             outputs are sampled 1 ns later.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cr_fifo_wr_arb;
    import cr_fifo_arb_pkg::*;

    localparam int N  = 4;
    localparam int DW = 106;
    localparam int IW = 2;

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic          err_clr = 1'b0;
    logic          busy;
    logic [IW-1:0] owner;
    logic          proto_err;

    int n_tests = 0;
    int n_fail  = 0;

    cr_fifo_wr_arb_if #(.N_REQ(N), .DATA_W(DW)) bus ();

    cr_fifo_wr_arb #(
        .N_REQ  (N),
        .DATA_W (DW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .busy      (busy),
        .owner     (owner),
        .proto_err (proto_err),
        .err_clr   (err_clr)
    );

    always #5 clk = ~clk;

    // Beat payload: marker, producer id, beat number
    function automatic logic [DW-1:0] d(input int i, input int b);
        return {8'hA5, 82'b0, 8'(i), 8'(b)};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic l, input int b);
        bus.req_valid[i]           = v;
        bus.req_last[i]            = l;
        bus.req_data[i*DW +: DW]   = d(i, b);
    endtask

    task automatic idle_inputs();
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 1'b0, 0);
        bus.fifo_full  = 1'b0;
        bus.fifo_afull = 1'b0;
        err_clr        = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        check("rst_busy",  busy,          1'b0);
        check("rst_owner", owner,         2'd0);
        check("rst_err",   proto_err,     1'b0);
        check("rst_ready", bus.req_ready, 4'b0000);
        check("rst_wen",   bus.fifo_wen,  1'b0);

        // ---------------- single-beat round robin ----------------
        do_reset();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 0) for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b1, 0);
            #1;
            check("rr_ready", bus.req_ready, 4'b0001 << (k % 4));
            check("rr_wen",   bus.fifo_wen,  1'b1);
            check("rr_wdata", bus.fifo_wdata, d(k % 4, 0));
        end

        // ---------------- packet lock ----------------
        do_reset();
        @(negedge clk); set_req(1, 1'b1, 1'b0, 0); set_req(2, 1'b1, 1'b1, 0); #1;
        check("lk_b0_data", bus.fifo_wdata, d(1, 0));
        check("lk_b0_rdy",  bus.req_ready,  4'b0010);
        check("lk_b0_busy", busy,           1'b0);
        @(negedge clk); set_req(1, 1'b1, 1'b0, 1); #1;
        check("lk_b1_busy", busy,           1'b1);
        check("lk_b1_own",  owner,          2'd1);
        check("lk_b1_data", bus.fifo_wdata, d(1, 1));
        check("lk_b1_rdy",  bus.req_ready,  4'b0010);
        @(negedge clk); set_req(1, 1'b1, 1'b1, 2); #1;
        check("lk_b2_busy", busy,           1'b1);
        check("lk_b2_data", bus.fifo_wdata, d(1, 2));
        @(negedge clk); set_req(1, 1'b0, 1'b0, 0); #1;
        check("lk_nx_busy", busy,           1'b0);
        check("lk_nx_data", bus.fifo_wdata, d(2, 0));
        check("lk_nx_rdy",  bus.req_ready,  4'b0100);
        @(negedge clk); set_req(2, 1'b0, 1'b0, 0); #1;
        check("lk_nx_own",  owner,          2'd1);

        // ---------------- afull gating ----------------
        do_reset();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (k == 0) begin bus.fifo_afull = 1'b1; set_req(0, 1'b1, 1'b1, 0); end
            #1;
            check("af_ready", bus.req_ready, 4'b0000);
            check("af_wen",   bus.fifo_wen,  1'b0);
        end
        @(negedge clk); bus.fifo_afull = 1'b0; #1;
        check("af_rel_rdy",  bus.req_ready,  4'b0001);
        check("af_rel_wen",  bus.fifo_wen,   1'b1);
        check("af_rel_data", bus.fifo_wdata, d(0, 0));

        // ---------------- full mid-packet ----------------
        do_reset();
        @(negedge clk); set_req(0, 1'b1, 1'b0, 0); set_req(3, 1'b1, 1'b1, 0); #1;
        check("fu_b0_data", bus.fifo_wdata, d(0, 0));
        @(negedge clk); set_req(0, 1'b1, 1'b0, 1); bus.fifo_afull = 1'b1; #1;
        check("fu_b1_wen",  bus.fifo_wen,   1'b1);
        check("fu_b1_rdy",  bus.req_ready,  4'b0001);
        check("fu_b1_data", bus.fifo_wdata, d(0, 1));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (k == 0) begin set_req(0, 1'b1, 1'b0, 2); bus.fifo_afull = 1'b0; bus.fifo_full = 1'b1; end
            #1;
            check("fu_st_wen",  bus.fifo_wen,   1'b0);
            check("fu_st_rdy",  bus.req_ready,  4'b0000);
            check("fu_st_data", bus.fifo_wdata, d(0, 2));
            check("fu_st_own",  owner,          2'd0);
            check("fu_st_busy", busy,           1'b1);
        end
        @(negedge clk); bus.fifo_full = 1'b0; #1;
        check("fu_b2_wen",  bus.fifo_wen,   1'b1);
        check("fu_b2_data", bus.fifo_wdata, d(0, 2));
        @(negedge clk); set_req(0, 1'b1, 1'b1, 3); #1;
        check("fu_b3_data", bus.fifo_wdata, d(0, 3));
        check("fu_b3_rdy",  bus.req_ready,  4'b0001);
        @(negedge clk); set_req(0, 1'b0, 1'b0, 0); #1;
        check("fu_nx_busy", busy,           1'b0);
        check("fu_nx_data", bus.fifo_wdata, d(3, 0));
        check("fu_nx_err",  proto_err,      1'b0);

        // ---------------- protocol error ----------------
        do_reset();
        @(negedge clk); set_req(2, 1'b1, 1'b0, 0); #1;
        check("pe_b0_rdy", bus.req_ready, 4'b0100);
        @(negedge clk); set_req(2, 1'b1, 1'b0, 1); bus.fifo_full = 1'b1; #1;
        check("pe_stall",  bus.fifo_wen,  1'b0);
        @(negedge clk); set_req(2, 1'b0, 1'b0, 1); #1;
        check("pe_drop",   proto_err,     1'b0);
        @(negedge clk); bus.fifo_full = 1'b0; #1;
        check("pe_set",    proto_err,     1'b1);
        check("pe_busy",   busy,          1'b1);
        @(negedge clk); #1;
        check("pe_sticky", proto_err,     1'b1);
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0; #1;
        check("pe_clr",    proto_err,     1'b0);
        @(negedge clk); set_req(2, 1'b1, 1'b0, 1); bus.fifo_full = 1'b1;
        @(negedge clk); set_req(2, 1'b0, 1'b0, 1); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0; bus.fifo_full = 1'b0; #1;
        check("pe_setclr", proto_err,     1'b1);
        @(negedge clk); set_req(2, 1'b1, 1'b1, 1); #1;
        check("pe_end_wen", bus.fifo_wen, 1'b1);
        @(negedge clk); set_req(2, 1'b0, 1'b0, 0); #1;
        check("pe_end_busy", busy,        1'b0);
        check("pe_end_err",  proto_err,   1'b1);

        // ---------------- async reset mid-packet ----------------
        do_reset();
        @(negedge clk); set_req(0, 1'b1, 1'b1, 0); #1;
        check("ar_single", bus.fifo_wen, 1'b1);
        @(negedge clk); set_req(0, 1'b0, 1'b0, 0); set_req(1, 1'b1, 1'b0, 0); #1;
        check("ar_b0_rdy", bus.req_ready, 4'b0010);
        @(negedge clk); set_req(1, 1'b1, 1'b0, 1); #1;
        check("ar_b1_busy", busy,  1'b1);
        check("ar_b1_own",  owner, 2'd1);
        #1 rst_n = 1'b0;
        #1;
        check("ar_rst_busy", busy,  1'b0);
        check("ar_rst_own",  owner, 2'd0);
        @(negedge clk); for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b1, 0);
        @(negedge clk); rst_n = 1'b1; #1;
        check("ar_rel_rdy",  bus.req_ready,  4'b0001);
        check("ar_rel_data", bus.fifo_wdata, d(0, 0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
